qos_issue_sched: RTL
====================

# qos_issue_sched

Issue scheduler for the 16-entry, ID-indexed QoS transaction tracker. It holds up to 16 pending requests, one slot per 4-bit ID, each with a 3-bit QoS. It issues one request at a time through a valid/ready port. The winner is the highest effective QoS, with round-robin tie-break among IDs. It sits between the request front-end and the downstream issue port, and exports the live pending max QoS to the rest of the design.

## Interface
- AGE_LIMIT, 8: cycles a non-offered pending slot waits before its effective QoS is promoted by 1. Legal range 1..255. Used only with aging compiled in.

- clk  in  1  clock
- rst  in  1  reset, synchronous, active-high
- req_vld  in  1  enqueue request
- req_id  in  4  slot/ID to enqueue
- req_qos  in  3  QoS of the request
- req_rdy  out  1  combinational; 1 when slot req_id is not pending
- iss_vld  out  1  registered; issue offer valid
- iss_id  out  4  registered; ID offered
- iss_qos  out  3  registered; effective QoS of the offered entry at selection
- iss_rdy  in  1  downstream accepts offer
- pend_cnt  out  5  registered; number of pending slots, including the offered one
- cur_max_qos  out  3  registered; max effective QoS over pending slots, 0 when none

## Operation
- Per slot: pending bit, stored qos[2:0], offered bit; aging counter when aging is enabled.
- Enqueue: when req_vld && req_rdy, the slot becomes pending with qos = req_qos, visible from the next cycle. When req_vld && !req_rdy, the request is ignored and slot contents are unchanged.
- Selection (combinational):
  - Candidates are pending, non-offered slots.
  - Winner has the max effective QoS.
  - Ties go to the first ID searching upward from (rr_ptr+1) mod 16, wrapping past 15 to 0.
- FSM states:
  - IDLE: iss_vld=0. If any candidate exists, load the winner into iss_id/iss_qos, set its offered bit, and go to OFFER.
  - OFFER: iss_vld=1, outputs held stable while iss_rdy=0.
  - On iss_vld && iss_rdy:
    - Clear the issued slot's pending and offered bits.
    - Set rr_ptr = iss_id.
    - In the same cycle, select from the remaining candidates, excluding the issued slot and any enqueue in this cycle.
    - If a winner exists, stay in OFFER with the new entry (back-to-back, 1 issue/cycle). Otherwise go to IDLE.
- No preemption: a registered offer is never replaced by a later higher-QoS arrival.
- An enqueue to the slot being issued in the same cycle sees req_rdy=0 and is dropped; the slot is free next cycle.
- pend_cnt and cur_max_qos reflect state after this cycle's enqueue/issue/aging updates, visible the next cycle.

## Timing
- Reset values:
  - all pending/offered bits 0, age counters 0, rr_ptr=15 (ID 0 wins the first tie)
  - state IDLE
  - iss_vld=0, iss_id=0, iss_qos=0, pend_cnt=0, cur_max_qos=0
  - req_rdy=1 for every ID
- rst asserted mid-offer clears everything on the next edge; the offer is lost, not issued.
- Latency from an empty scheduler: enqueue accepted at edge T, pending after T, iss_vld=1 after edge T+1 (2 cycles).
- Issue throughput: 1 per cycle while candidates remain and iss_rdy=1.

## Configuration
- QOS_AGING_EN defined:
  - Each pending, non-offered slot has an age counter of width $clog2(AGE_LIMIT+1), incremented every cycle.
  - When the counter reaches AGE_LIMIT, effective qos increments (saturating at 7) and the counter resets to 0.
  - Counter and promoted qos clear on enqueue.
  - The offered slot does not age.
  - iss_qos and cur_max_qos use effective QoS.
- QOS_AGING_EN undefined: effective QoS equals stored QoS; no counters are built, and AGE_LIMIT is ignored.

## Test plan
- Reset: hold rst 2 cycles -> iss_vld=0, iss_id=0, pend_cnt=0, cur_max_qos=0, req_rdy=1 for all IDs.
- No preemption, with iss_rdy=0:
  - Stimulus: enqueue ID3/qos2 at cycle 0, then ID7/qos5 at cycle 1.
  - Required: offer ID3/qos2 from cycle 2, pend_cnt=2, cur_max_qos=5.
  - Then raise iss_rdy -> ID7/qos5 on the next cycle, then iss_vld=0, pend_cnt=0.
- Round-robin ties:
  - Stimulus: enqueue ID2, ID5, ID9, all qos4, with iss_rdy=0; then hold iss_rdy=1.
  - Required: issues ID2, ID5, ID9 on consecutive cycles, with no iss_vld gap.
  - Then enqueue ID2 and ID5 again at qos4 -> ID2 wins (rr_ptr=9).
- Duplicate enqueue: ID4/qos1 pending, then req_vld with ID4/qos6 -> req_rdy=0, ID4 later issues with iss_qos=1.
- Aging (QOS_AGING_EN, AGE_LIMIT=4):
  - Stimulus: ID1/qos0 pending while ID2/qos3 is offered with iss_rdy=0.
  - Required: after 12 cycles ID1's effective QoS is 3 and cur_max_qos=3.
  - With aging compiled out: ID1's QoS stays 0.
- Reset mid-offer: iss_vld=1 on ID6 with 3 slots pending, assert rst 1 cycle -> all outputs return to reset values and req_rdy=1 for ID6.

Source files
------------

// File: rtl/qos_issue_sched.sv
// -----------------------------------------------------------------------------
// qos_issue_sched
//
// Issue scheduler for the 16-entry, ID-indexed QoS transaction tracker.
// Each 4-bit ID owns one slot holding a pending bit, a 3-bit QoS and an
// "offered" bit. One pending request at a time is offered downstream through
// a registered valid/ready port. The offered request is the one with the
// highest effective QoS. Ties are broken round-robin on ID.
//
// Optional feature (compile-time macro QOS_AGING_EN):
//   When defined, each waiting (pending, not offered) slot counts cycles.
//   Every AGE_LIMIT cycles its effective QoS is promoted by one, saturating
//   at 7. When undefined, no counters exist and AGE_LIMIT is ignored.
//
// Handshake rules (both ports):
//   A transfer happens on a rising clk edge where valid && ready are both 1.
//   Request port: req_rdy is combinational and is 1 while slot req_id is free.
//   Issue port: once iss_vld rises, iss_id/iss_qos stay stable until the
//   transfer. iss_vld never drops without a transfer, except on rst.
//
// Ports:
//   clk          clock
//   rst          synchronous, active-high reset
//   req_vld      enqueue request valid
//   req_id[3:0]  slot/ID to enqueue
//   req_qos[2:0] QoS of the request
//   req_rdy      slot req_id is not pending (combinational)
//   iss_vld      issue offer valid (registered)
//   iss_id[3:0]  offered ID (registered)
//   iss_qos[2:0] effective QoS of the offered entry when it was selected
//   iss_rdy      downstream accepts the offer
//   pend_cnt[4:0]     number of pending slots, including the offered one
//   cur_max_qos[2:0]  max effective QoS over pending slots, 0 when none
//   dbg_state[0:0]    scheduler FSM state (0 = IDLE, 1 = OFFER)
// -----------------------------------------------------------------------------
module qos_issue_sched #(
  parameter int AGE_LIMIT = 8
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       req_vld,
  input  logic [3:0] req_id,
  input  logic [2:0] req_qos,
  output logic       req_rdy,
  output logic       iss_vld,
  output logic [3:0] iss_id,
  output logic [2:0] iss_qos,
  input  logic       iss_rdy,
  output logic [4:0] pend_cnt,
  output logic [2:0] cur_max_qos,
  output logic [0:0] dbg_state
);

  localparam logic [0:0] ST_IDLE  = 1'b0;
  localparam logic [0:0] ST_OFFER = 1'b1;

  // ---------------------------------------------------------------------------
  // State
  // ---------------------------------------------------------------------------
  logic [0:0]  state_q, state_d;
  logic [15:0] pend_q, pend_d;
  logic [15:0] offd_q, offd_d;
  logic [2:0]  qos_q [16];
  logic [2:0]  qos_d [16];
  logic [3:0]  rr_ptr_q, rr_ptr_d;
  logic [3:0]  iss_id_q, iss_id_d;
  logic [2:0]  iss_qos_q, iss_qos_d;
  logic [4:0]  cnt_q, cnt_d;
  logic [2:0]  max_q, max_d;

`ifdef QOS_AGING_EN
  localparam int AGE_W = $clog2(AGE_LIMIT + 1);
  logic [AGE_W-1:0] age_q [16];
  logic [AGE_W-1:0] age_d [16];
`else
  // AGE_LIMIT only matters with aging compiled in.
  logic [31:0] unused_age_limit;
  assign unused_age_limit = 32'(AGE_LIMIT);
`endif

  // ---------------------------------------------------------------------------
  // Handshake decode
  // ---------------------------------------------------------------------------
  logic enq;
  logic accept;

  // The slot being issued is still pending this cycle, so an enqueue to it
  // sees req_rdy=0 and is dropped.
  assign req_rdy = ~pend_q[req_id];
  assign enq     = req_vld & req_rdy;
  assign accept  = (state_q == ST_OFFER) & iss_rdy;

  // ---------------------------------------------------------------------------
  // Winner selection
  // Candidates are pending, non-offered slots. The slot being issued is the
  // offered one, so it is never a candidate. A same-cycle enqueue is not
  // pending yet, so it is not a candidate either. On an accept the
  // round-robin base is the ID leaving this cycle, which becomes rr_ptr next.
  // ---------------------------------------------------------------------------
  logic [15:0] cand;
  logic [3:0]  sel_base;
  logic [3:0]  idx;
  logic        win_found;
  logic [3:0]  win_id;
  logic [2:0]  win_qos;

  assign cand     = pend_q & ~offd_q;
  assign sel_base = accept ? iss_id_q : rr_ptr_q;

  always_comb begin
    win_found = 1'b0;
    win_id    = '0;
    win_qos   = '0;
    idx       = '0;
    // Scan in round-robin order. A strict '>' keeps the first ID found among
    // equal-QoS candidates.
    for (int i = 0; i < 16; i++) begin
      idx = sel_base + 4'(i + 1);
      if (cand[idx] && (!win_found || (qos_q[idx] > win_qos))) begin
        win_found = 1'b1;
        win_id    = idx;
        win_qos   = qos_q[idx];
      end
    end
  end

  // ---------------------------------------------------------------------------
  // FSM and slot updates
  // ---------------------------------------------------------------------------
  logic load;

  always_comb begin
    state_d   = state_q;
    pend_d    = pend_q;
    offd_d    = offd_q;
    qos_d     = qos_q;
    rr_ptr_d  = rr_ptr_q;
    iss_id_d  = iss_id_q;
    iss_qos_d = iss_qos_q;
    load      = 1'b0;
`ifdef QOS_AGING_EN
    age_d     = age_q;
`endif

    case (state_q)
      ST_IDLE: begin
        if (win_found) begin
          load    = 1'b1;
          state_d = ST_OFFER;
        end
      end
      ST_OFFER: begin
        if (iss_rdy) begin
          pend_d[iss_id_q] = 1'b0;
          offd_d[iss_id_q] = 1'b0;
          rr_ptr_d         = iss_id_q;
          // Back-to-back issue: the next winner replaces the accepted offer.
          if (win_found) load = 1'b1;
          else           state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase

    if (load) begin
      offd_d[win_id] = 1'b1;
      iss_id_d       = win_id;
      iss_qos_d      = win_qos;
    end

`ifdef QOS_AGING_EN
    // Only waiting slots age. A slot loaded into the offer this cycle keeps
    // the QoS it was selected with, so iss_qos and cur_max_qos agree.
    for (int i = 0; i < 16; i++) begin
      if (cand[i] && !(load && (win_id == 4'(i)))) begin
        if (age_q[i] == AGE_W'(AGE_LIMIT - 1)) begin
          age_d[i] = '0;
          if (qos_q[i] != 3'd7) qos_d[i] = qos_q[i] + 3'd1;
        end else begin
          age_d[i] = age_q[i] + AGE_W'(1);
        end
      end
    end
`endif

    // An enqueued slot was free, so it cannot collide with the issue or
    // aging updates above.
    if (enq) begin
      pend_d[req_id] = 1'b1;
      qos_d[req_id]  = req_qos;
`ifdef QOS_AGING_EN
      age_d[req_id]  = '0;
`endif
    end
  end

  // Status outputs are computed from next state so they are registered
  // views of the post-update slot table.
  always_comb begin
    cnt_d = '0;
    max_d = '0;
    for (int i = 0; i < 16; i++) begin
      cnt_d = cnt_d + 5'(pend_d[i]);
      if (pend_d[i] && (qos_d[i] > max_d)) max_d = qos_d[i];
    end
  end

  // ---------------------------------------------------------------------------
  // Registers
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= ST_IDLE;
      pend_q    <= '0;
      offd_q    <= '0;
      rr_ptr_q  <= 4'd15;
      iss_id_q  <= '0;
      iss_qos_q <= '0;
      cnt_q     <= '0;
      max_q     <= '0;
      for (int i = 0; i < 16; i++) begin
        qos_q[i] <= '0;
`ifdef QOS_AGING_EN
        age_q[i] <= '0;
`endif
      end
    end else begin
      state_q   <= state_d;
      pend_q    <= pend_d;
      offd_q    <= offd_d;
      rr_ptr_q  <= rr_ptr_d;
      iss_id_q  <= iss_id_d;
      iss_qos_q <= iss_qos_d;
      cnt_q     <= cnt_d;
      max_q     <= max_d;
      for (int i = 0; i < 16; i++) begin
        qos_q[i] <= qos_d[i];
`ifdef QOS_AGING_EN
        age_q[i] <= age_d[i];
`endif
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Outputs
  // ---------------------------------------------------------------------------
  assign iss_vld     = (state_q == ST_OFFER);
  assign iss_id      = iss_id_q;
  assign iss_qos     = iss_qos_q;
  assign pend_cnt    = cnt_q;
  assign cur_max_qos = max_q;
  assign dbg_state   = state_q;

endmodule
